// File: rtl/seg_capture.sv
// Captures three two-digit prices from a scanned, multiplexed 7-segment display.
// Each digit must be stable for SETTLE cycles before it is sampled; a frame is digits 0..5 in order.
module seg_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    output logic [6:0] price_put,
    output logic [6:0] price_need,
    output logic [6:0] price_out,
    output logic       frame_valid,
    output logic       code_err,
    output logic       seq_err,
    output logic       busy
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, OUTPUT = 2'd2} state_t;

    state_t        state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [13:0]   in_prev_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    digit_reg [6];
    logic [6:0]    price_put_reg, price_need_reg, price_out_reg;
    logic          frame_valid_reg, code_err_reg, seq_err_reg;
    logic          code_err_next, seq_err_next;

    logic          sample, take, blank, one_hot, seg_ok, code_ok, wr_en, load;
    logic [2:0]    dig_idx;
    logic [3:0]    dig_val;

    // Counter saturates one past SETTLE-1 so a stable period yields exactly one sample.
    always_comb begin
        cnt_next = '0;
        if ({sel, seg} == in_prev_reg)
            cnt_next = (cnt_reg == CW'(SETTLE)) ? cnt_reg : cnt_reg + 1'b1;
    end
    assign sample = (cnt_next == CW'(SETTLE - 1));
    assign blank  = (sel == 6'h3F);
    assign take   = sample && !blank;

    always_comb begin
        one_hot = 1'b0;
        dig_idx = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (sel == ~(6'd1 << k)) begin
                one_hot = 1'b1;
                dig_idx = 3'(k);
            end
        end
    end

    always_comb begin
        seg_ok  = 1'b1;
        dig_val = 4'd0;
        case (seg[6:0])
            7'b1000000: dig_val = 4'd0;
            7'b1111001: dig_val = 4'd1;
            7'b0100100: dig_val = 4'd2;
            7'b0110000: dig_val = 4'd3;
            7'b0011001: dig_val = 4'd4;
            7'b0010010: dig_val = 4'd5;
            7'b0000010: dig_val = 4'd6;
            7'b1111000: dig_val = 4'd7;
            7'b0000000: dig_val = 4'd8;
            7'b0010000: dig_val = 4'd9;
            default:    seg_ok  = 1'b0;
        endcase
    end

    // Decimal point is lit (0) on the tens digits, i.e. even indices.
    assign code_ok = seg_ok && (!one_hot || (seg[7] == dig_idx[0]));

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        timer_next    = timer_reg;
        wr_en         = 1'b0;
        load          = 1'b0;
        code_err_next = 1'b0;
        seq_err_next  = 1'b0;
        case (state_reg)
            COLLECT: begin
                timer_next = timer_reg + 1'b1;
                if (take) begin
                    if (!code_ok) begin
                        code_err_next = 1'b1;
                        state_next    = IDLE;
                        idx_next      = 3'd0;
                    end else if (one_hot && dig_idx == idx_reg) begin
                        wr_en      = 1'b1;
                        timer_next = TW'(1);
                        if (idx_reg == 3'd5) begin
                            load       = 1'b1;
                            state_next = OUTPUT;
                            idx_next   = 3'd0;
                        end else begin
                            idx_next = idx_reg + 3'd1;
                        end
                    end else if (one_hot && dig_idx == idx_reg - 3'd1) begin
                        wr_en      = 1'b1;
                        timer_next = TW'(1);
                    end else if (one_hot && dig_idx == 3'd0) begin
                        seq_err_next = 1'b1;
                        wr_en        = 1'b1;
                        idx_next     = 3'd1;
                        timer_next   = TW'(1);
                    end else begin
                        seq_err_next = 1'b1;
                        state_next   = IDLE;
                        idx_next     = 3'd0;
                    end
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    seq_err_next = 1'b1;
                    state_next   = IDLE;
                    idx_next     = 3'd0;
                end
            end
            default: begin
                // OUTPUT lasts one cycle and behaves like IDLE for any sample in it.
                state_next = IDLE;
                idx_next   = 3'd0;
                timer_next = '0;
                if (take && code_ok && one_hot && dig_idx == 3'd0) begin
                    wr_en      = 1'b1;
                    idx_next   = 3'd1;
                    timer_next = TW'(1);
                    state_next = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            timer_reg       <= '0;
            in_prev_reg     <= '0;
            cnt_reg         <= '0;
            price_put_reg   <= '0;
            price_need_reg  <= '0;
            price_out_reg   <= '0;
            frame_valid_reg <= 1'b0;
            code_err_reg    <= 1'b0;
            seq_err_reg     <= 1'b0;
            for (int i = 0; i < 6; i++) digit_reg[i] <= '0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            timer_reg       <= timer_next;
            in_prev_reg     <= {sel, seg};
            cnt_reg         <= cnt_next;
            frame_valid_reg <= load;
            code_err_reg    <= code_err_next;
            seq_err_reg     <= seq_err_next;
            for (int i = 0; i < 6; i++)
                if (wr_en && dig_idx == 3'(i)) digit_reg[i] <= dig_val;
            if (load) begin
                // Digit 5 is being accepted this cycle, so it comes straight from the decoder.
                price_put_reg  <= 7'(digit_reg[0]) * 7'd10 + 7'(digit_reg[1]);
                price_need_reg <= 7'(digit_reg[2]) * 7'd10 + 7'(digit_reg[3]);
                price_out_reg  <= 7'(digit_reg[4]) * 7'd10 + 7'(dig_val);
            end
        end
    end

    assign price_put   = price_put_reg;
    assign price_need  = price_need_reg;
    assign price_out   = price_out_reg;
    assign frame_valid = frame_valid_reg;
    assign code_err    = code_err_reg;
    assign seq_err     = seq_err_reg;
    assign busy        = (state_reg == COLLECT);
endmodule

// File: tb/tb_seg_capture.sv
// Scenario bench for seg_capture: directed frames plus randomized frames with injected faults.
module tb_seg_capture;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sel;
    logic [7:0] seg;
    logic [6:0] price_put, price_need, price_out;
    logic       frame_valid, code_err, seq_err, busy;

    always #5 clk = ~clk;

    seg_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sel(sel), .seg(seg),
        .price_put(price_put), .price_need(price_need), .price_out(price_out),
        .frame_valid(frame_valid), .code_err(code_err), .seq_err(seq_err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drv_cyc = 0;
    int fv_cnt = 0, ce_cnt = 0, se_cnt = 0;
    int fv_cyc = 0, se_cyc = 0;
    int exp_put = 0, exp_need = 0, exp_out = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin fv_cnt++; fv_cyc = cyc; end
        if (code_err) ce_cnt++;
        if (seq_err) begin se_cnt++; se_cyc = cyc; end
    end

    function automatic logic [5:0] sel_of(input int k);
        logic [5:0] s;
        s = 6'h3F;
        s[k] = 1'b0;
        return s;
    endfunction

    function automatic logic [7:0] seg_of(input int k, input int v);
        return {((k % 2) == 1) ? 1'b1 : 1'b0, seg_tab[v]};
    endfunction

    function automatic bit in_table(input logic [6:0] c);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic hold(input logic [5:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg = g;
        drv_cyc = cyc;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic digit(input int k, input int v);
        hold(sel_of(k), seg_of(k, v), 8);
    endtask

    task automatic blank(input int n);
        hold(6'h3F, 8'hFF, n);
    endtask

    task automatic frame(input int d [6]);
        for (int k = 0; k < 6; k++) digit(k, d[k]);
    endtask

    task automatic expect_frame(input int d [6]);
        exp_put  = d[0] * 10 + d[1];
        exp_need = d[2] * 10 + d[3];
        exp_out  = d[4] * 10 + d[5];
    endtask

    task automatic check_prices(input string tag);
        checks++;
        if (price_put !== 7'(exp_put) || price_need !== 7'(exp_need) || price_out !== 7'(exp_out)) begin
            errors++;
            $display("FAIL %s_prices got %0d/%0d/%0d want %0d/%0d/%0d", tag,
                     price_put, price_need, price_out, exp_put, exp_need, exp_out);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sel = 6'h3F;
        seg = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({price_put, price_need, price_out} !== 21'd0) begin
            errors++;
            $display("FAIL reset_prices got %h want 0", {price_put, price_need, price_out});
        end
        checks++;
        if ({frame_valid, code_err, seq_err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {frame_valid, code_err, seq_err, busy});
        end
        rst = 1'b0;
        blank(3);
        $display("test_reset: outputs cleared");
    endtask

    task automatic test_normal;
        int d [6] = '{2, 5, 1, 8, 0, 7};
        int b_fv, d5_cyc;
        b_fv = fv_cnt;
        for (int k = 0; k < 5; k++) digit(k, d[k]);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy got %b want 1", busy); end
        digit(5, d[5]);
        d5_cyc = drv_cyc;
        blank(4);
        expect_frame(d);
        checks++;
        if (fv_cnt - b_fv != 1) begin errors++; $display("FAIL normal_fv_count got %0d want 1", fv_cnt - b_fv); end
        checks++;
        if (fv_cyc - d5_cyc != SETTLE) begin
            errors++;
            $display("FAIL normal_latency got %0d want %0d", fv_cyc - d5_cyc, SETTLE);
        end
        check_prices("normal");
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL normal_idle_busy got %b want 0", busy); end
        $display("test_normal: put=%0d need=%0d out=%0d", price_put, price_need, price_out);
    endtask

    task automatic test_glitch;
        int d [6] = '{4, 3, 9, 6, 1, 2};
        int b_fv, b_se;
        b_fv = fv_cnt;
        b_se = se_cnt;
        digit(0, d[0]);
        digit(1, d[1]);
        hold(sel_of(3), seg_of(3, 5), SETTLE - 1);   // too short to be sampled
        blank(1);
        for (int k = 2; k < 6; k++) digit(k, d[k]);
        blank(4);
        expect_frame(d);
        checks++;
        if (se_cnt != b_se) begin errors++; $display("FAIL glitch_seq_err got %0d want 0", se_cnt - b_se); end
        checks++;
        if (fv_cnt - b_fv != 1) begin errors++; $display("FAIL glitch_fv_count got %0d want 1", fv_cnt - b_fv); end
        check_prices("glitch");
        $display("test_glitch: put=%0d need=%0d out=%0d", price_put, price_need, price_out);
    endtask

    task automatic test_illegal;
        int b_ce, b_fv;
        b_ce = ce_cnt;
        b_fv = fv_cnt;
        digit(0, 7);
        digit(1, 7);
        hold(sel_of(2), 8'hFF, 8);
        blank(3);
        checks++;
        if (ce_cnt - b_ce != 1) begin errors++; $display("FAIL illegal_code_err got %0d want 1", ce_cnt - b_ce); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b want 0", busy); end
        checks++;
        if (fv_cnt != b_fv) begin errors++; $display("FAIL illegal_fv got %0d want 0", fv_cnt - b_fv); end
        check_prices("illegal");
        $display("test_illegal: code_err pulses=%0d", ce_cnt - b_ce);
    endtask

    task automatic test_order;
        int b_se, b_fv;
        b_se = se_cnt;
        b_fv = fv_cnt;
        digit(0, 1);
        digit(1, 2);
        digit(3, 3);
        blank(3);
        checks++;
        if (se_cnt - b_se != 1) begin errors++; $display("FAIL order_seq_err got %0d want 1", se_cnt - b_se); end
        checks++;
        if (fv_cnt != b_fv) begin errors++; $display("FAIL order_fv got %0d want 0", fv_cnt - b_fv); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL order_busy got %b want 0", busy); end
        $display("test_order: seq_err pulses=%0d", se_cnt - b_se);
    endtask

    task automatic test_timeout;
        int b_se, d2_cyc, want;
        b_se = se_cnt;
        digit(0, 5);
        digit(1, 5);
        sel = sel_of(2);
        seg = seg_of(2, 5);
        d2_cyc = cyc;
        // Accepted in the SETTLE-th cycle; timeout pulse TIMEOUT cycles later.
        want = d2_cyc + SETTLE - 1 + TIMEOUT;
        repeat (SETTLE + TIMEOUT - 6) begin @(posedge clk); #1; end
        checks++;
        if (se_cnt != b_se) begin errors++; $display("FAIL timeout_early got %0d want 0", se_cnt - b_se); end
        repeat (12) begin @(posedge clk); #1; end
        checks++;
        if (se_cnt - b_se != 1) begin errors++; $display("FAIL timeout_count got %0d want 1", se_cnt - b_se); end
        checks++;
        if (se_cyc < want - 1 || se_cyc > want + 1) begin
            errors++;
            $display("FAIL timeout_cycle got %0d want %0d", se_cyc - d2_cyc, want - d2_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
        blank(3);
        $display("test_timeout: seq_err after %0d cycles", se_cyc - d2_cyc);
    endtask

    task automatic test_reset_mid;
        int d [6] = '{9, 9, 0, 1, 5, 0};
        int b_ce, b_se, b_fv;
        b_ce = ce_cnt;
        b_se = se_cnt;
        b_fv = fv_cnt;
        for (int k = 0; k < 4; k++) digit(k, 3);
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        exp_put = 0; exp_need = 0; exp_out = 0;
        check_prices("rstmid");
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        rst = 1'b0;
        blank(3);
        checks++;
        if (ce_cnt != b_ce || se_cnt != b_se || fv_cnt != b_fv) begin
            errors++;
            $display("FAIL rstmid_pulses got %0d/%0d/%0d want 0/0/0", ce_cnt - b_ce, se_cnt - b_se, fv_cnt - b_fv);
        end
        frame(d);
        blank(4);
        expect_frame(d);
        check_prices("rstmid_after");
        $display("test_reset_mid: put=%0d need=%0d out=%0d", price_put, price_need, price_out);
    endtask

    task automatic test_back_to_back;
        int a [6] = '{1, 2, 3, 4, 5, 6};
        int b [6] = '{6, 5, 4, 3, 2, 1};
        int b_fv;
        b_fv = fv_cnt;
        frame(a);
        frame(b);
        blank(4);
        expect_frame(b);
        checks++;
        if (fv_cnt - b_fv != 2) begin errors++; $display("FAIL b2b_fv_count got %0d want 2", fv_cnt - b_fv); end
        check_prices("b2b");
        $display("test_back_to_back: frames=%0d", fv_cnt - b_fv);
    endtask

    task automatic test_random;
        for (int it = 0; it < 20; it++) begin
            int d [6];
            int kind, j, b_fv, b_ce, b_se, w_fv, w_ce, w_se;
            logic [7:0] bad;
            for (int k = 0; k < 6; k++) d[k] = int'($urandom_range(9));
            kind = int'($urandom_range(2));
            b_fv = fv_cnt; b_ce = ce_cnt; b_se = se_cnt;
            w_fv = 0; w_ce = 0; w_se = 0;
            j = 0;
            if (kind == 0) begin
                frame(d);
                expect_frame(d);
                w_fv = 1;
            end else if (kind == 1) begin
                j = int'($urandom_range(1, 5));
                for (int k = 0; k < j; k++) digit(k, d[k]);
                if ($urandom_range(1) == 1) begin
                    bad = seg_of(j, d[j]) ^ 8'h80;
                end else begin
                    bad = seg_of(j, d[j]);
                    while (in_table(bad[6:0])) bad[6:0] = 7'($urandom);
                end
                hold(sel_of(j), bad, 8);
                w_ce = 1;
            end else begin
                j = int'($urandom_range(1, 4));
                for (int k = 0; k < j; k++) digit(k, d[k]);
                digit(j + 1, d[j + 1]);
                w_se = 1;
            end
            blank(3);
            checks++;
            if (fv_cnt - b_fv != w_fv || ce_cnt - b_ce != w_ce || se_cnt - b_se != w_se) begin
                errors++;
                $display("FAIL random_%0d_pulses got fv=%0d ce=%0d se=%0d want fv=%0d ce=%0d se=%0d",
                         it, fv_cnt - b_fv, ce_cnt - b_ce, se_cnt - b_se, w_fv, w_ce, w_se);
            end
            check_prices("random");
            $display("test_random %0d: kind=%0d pos=%0d put=%0d need=%0d out=%0d",
                     it, kind, j, price_put, price_need, price_out);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_glitch();
        test_illegal();
        test_order();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4, giving the number of consecutive identical {sel,seg} cycles required before a sample is taken.
REQ-002 The block SHALL have parameter TIMEOUT, default 100000, giving the maximum number of cycles allowed between accepted digits within a frame.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port sel, input, 6 bits: scanned digit select, active-low one-hot; 6'b111111 means blank.
REQ-006 Port seg, input, 8 bits: common-anode segment code, active-low; bit7 is the decimal point, bits6:0 are segments g..a.
REQ-007 Port price_put, output, 7 bits: decoded value from digits 0 (tens) and 1 (ones).
REQ-008 Port price_need, output, 7 bits: decoded value from digits 2 (tens) and 3 (ones).
REQ-009 Port price_out, output, 7 bits: decoded value from digits 4 (tens) and 5 (ones).
REQ-010 Port frame_valid, output, 1 bit: one-cycle pulse when a complete frame has been captured.
REQ-011 Port code_err, output, 1 bit: one-cycle pulse when an illegal segment or decimal-point code is sampled.
REQ-012 Port seq_err, output, 1 bit: one-cycle pulse on a digit-order violation or a timeout.
REQ-013 Port busy, output, 1 bit: high while the state machine is in the COLLECT state.

Function
REQ-014 Digit k SHALL be selected by sel equal to 6'b111111 with bit k cleared; the digits SHALL be expected in order 0 through 5.
REQ-015 Bits6:0 of seg SHALL decode as follows, and any other value SHALL be illegal: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 Bit7 of seg SHALL be 0 (point lit) on digits 0, 2 and 4, and 1 on digits 1, 3 and 5; any mismatch SHALL be treated as an illegal code.
REQ-017 A stability counter SHALL clear whenever {sel,seg} differs from the previous cycle's value, and a single sample event SHALL occur in the cycle in which the counter reaches SETTLE-1, i.e. at most one sample per stable period.
REQ-018 Sample events with sel equal to 6'b111111 SHALL be ignored in every state and SHALL NOT restart the timeout.
REQ-019 The state machine SHALL have three states: IDLE, COLLECT (with a digit index idx from 1 to 5) and OUTPUT.
REQ-020 In IDLE, a legal sample of digit 0 SHALL store that digit, set idx to 1 and move to COLLECT; every other sample SHALL be ignored without raising an error.
REQ-021 In COLLECT, a legal sample of digit idx SHALL store the digit and increment idx, and accepting digit 5 SHALL move the machine to OUTPUT.
REQ-022 In COLLECT, a legal sample of digit idx-1 SHALL overwrite that stored digit without raising an error.
REQ-023 In COLLECT, a legal sample of digit 0 (when idx is not 1) SHALL pulse seq_err and restart the frame with idx set to 1.
REQ-024 In COLLECT, a sample of any other sel pattern, including a pattern that is not one-hot, SHALL pulse seq_err and return the machine to IDLE.
REQ-025 In COLLECT, an illegal code SHALL pulse code_err and return the machine to IDLE; if the sel pattern is also wrong, code_err SHALL take priority and only code_err SHALL pulse.
REQ-026 In COLLECT, when TIMEOUT cycles elapse without an accepted sample, the block SHALL pulse seq_err and return to IDLE.
REQ-027 In OUTPUT, the block SHALL compute each value as tens*10+ones (range 0-99, no overflow possible), load all three outputs simultaneously, pulse frame_valid, and return to IDLE in the next cycle.
REQ-028 frame_valid and the updated outputs SHALL appear exactly one cycle after the cycle in which the sample of digit 5 is accepted.
REQ-029 The price outputs SHALL change only in OUTPUT and SHALL hold their values otherwise, including through aborted frames.
REQ-030 A sample event occurring in the OUTPUT cycle SHALL be processed as if the machine were in IDLE.

Reset
REQ-031 While rst is high, the block SHALL force the state to IDLE, idx to 0, the counters to 0, all stored digits to 0, price_put, price_need and price_out to 0, and frame_valid, code_err, seq_err and busy to 0.
REQ-032 Assertion of rst in the middle of a frame SHALL discard the partial frame without pulsing any error output.

Verification
REQ-033 Bench scenario, normal frame: with SETTLE=4, each digit held for 8 cycles with codes for 2,5,1,8,0,7 and correct decimal points -> exactly one frame_valid pulse, with price_put=25, price_need=18, price_out=7.
REQ-034 Bench scenario, glitch: one digit held for only 3 cycles -> no sample is taken; when the digit is then re-held for 8 cycles, the frame completes normally.
REQ-035 Bench scenario, illegal code: digit 2 driven with seg=8'hFF -> code_err pulses, busy falls, and the outputs keep their previous values.
REQ-036 Bench scenario, order violation: sequence digit 0, digit 1, digit 3 -> seq_err pulses once and no frame_valid pulse occurs.
REQ-037 Bench scenario, timeout: with TIMEOUT=50, the frame stalls after digit 2 -> seq_err pulses 50 cycles after the last accepted sample.
REQ-038 Bench scenario, reset mid-frame: rst asserted after digit 3 -> all outputs read 0 with no error pulse, and a subsequent full frame is captured correctly.
